// File: rtl/eco32_core_jpu_rdr.sv
// Jump-redirect buffer: one capture slot per hardware thread, round-robin
// arbitration into a single output register handshaked with the IFU.
package eco32_core_jpu_rdr_pkg;
  typedef struct packed {
    logic        evt_ack;
    logic [3:0]  asid;
    logic [1:0]  pid;
    logic [15:0] isw;
    logic [31:0] v_addr;
    logic        fault;
  } rdr_pl_t;
endpackage

module eco32_core_jpu_rdr_slot
  import eco32_core_jpu_rdr_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    cap,
  input  logic    clr,
  input  logic    take,
  input  rdr_pl_t d,
  output logic    vld,
  output rdr_pl_t q
);
  // A capture wins over take/clear so a same-cycle move-out keeps the new entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (cap) begin
      vld <= 1'b1;
      q   <= d;
    end else if (clr || take) begin
      vld <= 1'b0;
    end
  end
endmodule

module eco32_core_jpu_rdr
  import eco32_core_jpu_rdr_pkg::*;
#(
  parameter bit ALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stb,
  input  logic        i_tid,
  input  logic        i_evt_ack,
  input  logic [3:0]  i_asid,
  input  logic [1:0]  i_pid,
  input  logic [15:0] i_isw,
  input  logic [31:0] i_v_addr,
  input  logic        i_flush,
  input  logic        i_flush_tid,
  input  logic        i_ack,
  output logic        o_req,
  output logic        o_tid,
  output logic        o_evt_ack,
  output logic [3:0]  o_asid,
  output logic [1:0]  o_pid,
  output logic [15:0] o_isw,
  output logic [31:0] o_v_addr,
  output logic        o_fault,
  output logic [1:0]  fco_thr_busy,
  output logic [15:0] o_drop_cnt
);
  localparam int NUM_THR = 2;

  rdr_pl_t                    pl_in;
  rdr_pl_t [NUM_THR-1:0]      slot_q;
  rdr_pl_t                    out_pl;
  logic    [NUM_THR-1:0]      slot_vld, cap, clr, take, cand;
  logic                       out_vld, out_tid, last_tid;
  logic                       out_kill, out_free, load, win, drop;

  always_comb begin
    pl_in         = '0;
    pl_in.evt_ack = i_evt_ack;
    pl_in.asid    = i_asid;
    pl_in.pid     = i_pid;
    pl_in.isw     = i_isw;
    pl_in.v_addr  = i_v_addr;
    pl_in.fault   = ALIGN_CHK && (i_v_addr[1:0] != 2'b00);
  end

  for (genvar t = 0; t < NUM_THR; t++) begin : g_thr
    // A flushed thread neither captures nor competes for the output this cycle.
    assign clr[t]  = i_flush && (i_flush_tid == 1'(t));
    assign cap[t]  = i_stb && (i_tid == 1'(t)) && !clr[t];
    assign cand[t] = slot_vld[t] && !clr[t];
    assign take[t] = load && (win == 1'(t));
    assign fco_thr_busy[t] = slot_vld[t] || (out_vld && (out_tid == 1'(t)));

    eco32_core_jpu_rdr_slot u_slot (
      .clk  (clk),
      .rst  (rst),
      .cap  (cap[t]),
      .clr  (clr[t]),
      .take (take[t]),
      .d    (pl_in),
      .vld  (slot_vld[t]),
      .q    (slot_q[t])
    );
  end

  assign out_kill = i_flush && out_vld && (out_tid == i_flush_tid);
  assign out_free = !out_vld || i_ack || out_kill;
  assign load     = out_free && (|cand);
  assign win      = (&cand) ? ~last_tid : cand[1];
  assign drop     = |(cap & slot_vld & ~take);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_tid  <= 1'b0;
      out_pl   <= '0;
      last_tid <= 1'b1;
    end else if (load) begin
      out_vld  <= 1'b1;
      out_tid  <= win;
      out_pl   <= slot_q[win];
      last_tid <= win;
    end else if (out_kill || i_ack) begin
      out_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      o_drop_cnt <= '0;
    else if (drop && (o_drop_cnt != 16'hFFFF))
      o_drop_cnt <= o_drop_cnt + 16'd1;
  end

  assign o_req     = out_vld;
  assign o_tid     = out_tid;
  assign o_evt_ack = out_pl.evt_ack;
  assign o_asid    = out_pl.asid;
  assign o_pid     = out_pl.pid;
  assign o_isw     = out_pl.isw;
  assign o_v_addr  = out_pl.v_addr;
  assign o_fault   = out_pl.fault;
endmodule

// File: tb/tb_eco32_core_jpu_rdr.sv
// Scoreboard bench for the jump-redirect buffer: directed scenarios then
// randomized traffic, checked against a cycle-level behavioural model.
module tb_eco32_core_jpu_rdr;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_stb, i_tid, i_evt_ack;
  logic [3:0]  i_asid;
  logic [1:0]  i_pid;
  logic [15:0] i_isw;
  logic [31:0] i_v_addr;
  logic        i_flush, i_flush_tid, i_ack;

  logic        o_req, o_tid, o_evt_ack, o_fault;
  logic [3:0]  o_asid;
  logic [1:0]  o_pid;
  logic [15:0] o_isw;
  logic [31:0] o_v_addr;
  logic [1:0]  fco_thr_busy;
  logic [15:0] o_drop_cnt;

  logic        n_req, n_tid, n_evt_ack, n_fault;
  logic [3:0]  n_asid;
  logic [1:0]  n_pid;
  logic [15:0] n_isw;
  logic [31:0] n_v_addr;
  logic [1:0]  n_busy;
  logic [15:0] n_drop;

  always #5 clk = ~clk;

  eco32_core_jpu_rdr #(.ALIGN_CHK(1'b1)) u_dut (
    .clk(clk), .rst(rst), .i_stb(i_stb), .i_tid(i_tid), .i_evt_ack(i_evt_ack),
    .i_asid(i_asid), .i_pid(i_pid), .i_isw(i_isw), .i_v_addr(i_v_addr),
    .i_flush(i_flush), .i_flush_tid(i_flush_tid), .i_ack(i_ack),
    .o_req(o_req), .o_tid(o_tid), .o_evt_ack(o_evt_ack), .o_asid(o_asid),
    .o_pid(o_pid), .o_isw(o_isw), .o_v_addr(o_v_addr), .o_fault(o_fault),
    .fco_thr_busy(fco_thr_busy), .o_drop_cnt(o_drop_cnt)
  );

  eco32_core_jpu_rdr #(.ALIGN_CHK(1'b0)) u_nochk (
    .clk(clk), .rst(rst), .i_stb(i_stb), .i_tid(i_tid), .i_evt_ack(i_evt_ack),
    .i_asid(i_asid), .i_pid(i_pid), .i_isw(i_isw), .i_v_addr(i_v_addr),
    .i_flush(i_flush), .i_flush_tid(i_flush_tid), .i_ack(i_ack),
    .o_req(n_req), .o_tid(n_tid), .o_evt_ack(n_evt_ack), .o_asid(n_asid),
    .o_pid(n_pid), .o_isw(n_isw), .o_v_addr(n_v_addr), .o_fault(n_fault),
    .fco_thr_busy(n_busy), .o_drop_cnt(n_drop)
  );

  typedef struct packed {
    logic        tid;
    logic        evt;
    logic [3:0]  asid;
    logic [1:0]  pid;
    logic [15:0] isw;
    logic [31:0] va;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  // Reference model state: what each thread has waiting, what the IFU sees.
  bit   m_v[2];
  exp_t m_s[2];
  bit   m_ov;
  exp_t m_o;
  bit   m_last;
  int   m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_busy();
    return {m_v[1] || (m_ov && m_o.tid), m_v[0] || (m_ov && !m_o.tid)};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t got;
      chk("o_req", 64'(o_req), 64'(m_ov));
      chk("busy", 64'(fco_thr_busy), 64'(exp_busy()));
      chk("drop_cnt", 64'(o_drop_cnt), 64'(m_drop));
      if (n_req) chk("nochk_fault", 64'(n_fault), 64'd0);
      if (o_req && i_ack && !rst && !(i_flush && i_flush_tid == o_tid)) begin
        got = '{o_tid, o_evt_ack, o_asid, o_pid, o_isw, o_v_addr, o_fault};
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL xfer_unexpected: got %0h expected none at %0t", got, $time);
        end else begin
          chk("xfer", 64'(got), 64'(sb_q.pop_front()));
        end
      end
    end
  end

  task automatic model_update();
    bit c[2];
    bit w;
    if (rst) begin
      m_v = '{1'b0, 1'b0};
      m_ov = 1'b0;
      m_o = '0;
      m_last = 1'b1;
      m_drop = 0;
    end else begin
      for (int t = 0; t < 2; t++) c[t] = m_v[t] && !(i_flush && i_flush_tid == 1'(t));
      if (!m_ov || i_ack || (i_flush && m_o.tid == i_flush_tid)) begin
        m_ov = 1'b0;
        if (c[0] || c[1]) begin
          w = (c[0] && c[1]) ? !m_last : c[1];
          m_o = m_s[w];
          m_ov = 1'b1;
          m_last = w;
          m_v[w] = 1'b0;
        end
      end
      if (i_flush) m_v[i_flush_tid] = 1'b0;
      if (i_stb && !(i_flush && i_flush_tid == i_tid)) begin
        if (m_v[i_tid] && m_drop < 65535) m_drop++;
        m_v[i_tid] = 1'b1;
        m_s[i_tid] = '{i_tid, i_evt_ack, i_asid, i_pid, i_isw, i_v_addr, (i_v_addr[1:0] != 2'b00)};
      end
    end
  endtask

  task automatic cyc();
    if (!rst && m_ov && i_ack && !(i_flush && i_flush_tid == m_o.tid)) sb_q.push_back(m_o);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    i_stb = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic jump(input logic tid, input logic [31:0] va, input logic [15:0] isw);
    i_stb = 1'b1;
    i_tid = tid;
    i_v_addr = va;
    i_isw = isw;
    i_evt_ack = 1'($urandom);
    i_asid = 4'($urandom);
    i_pid = 2'($urandom);
  endtask

  initial begin
    rst = 1'b1; i_ack = 1'b0; i_tid = 1'b0; i_evt_ack = 1'b0; i_asid = '0;
    i_pid = '0; i_isw = '0; i_v_addr = '0; i_flush_tid = 1'b0;
    idle();
    cyc();
    mon_en = 1'b1;
    cyc();
    rst = 1'b0;

    // single aligned jump, ack held high
    i_ack = 1'b1;
    jump(1'b0, 32'h0000_1000, 16'h00A5); cyc();
    idle(); repeat (3) cyc();
    // misaligned target
    jump(1'b1, 32'h0000_1002, 16'h1234); cyc();
    idle(); repeat (3) cyc();

    // round-robin with both slots filled behind a stalled output
    i_ack = 1'b0;
    jump(1'b1, 32'h10, 16'h1); cyc();
    jump(1'b0, 32'h20, 16'h2); cyc();
    jump(1'b1, 32'h30, 16'h3); cyc();
    idle(); cyc();
    i_ack = 1'b1; repeat (4) cyc();
    i_ack = 1'b0;
    jump(1'b0, 32'h40, 16'h4); cyc();
    jump(1'b1, 32'h50, 16'h5); cyc();
    jump(1'b0, 32'h60, 16'h6); cyc();
    idle(); cyc();
    i_ack = 1'b1; repeat (4) cyc();

    // stall and overwrite on thread 1
    i_ack = 1'b0;
    jump(1'b1, 32'h100, 16'h0); cyc();
    jump(1'b1, 32'h200, 16'h0); cyc();
    jump(1'b1, 32'h300, 16'h0); cyc();
    idle(); repeat (3) cyc();
    i_ack = 1'b1; repeat (3) cyc();

    // flush of thread 0 while thread 1 waits
    i_ack = 1'b0;
    jump(1'b0, 32'h500, 16'h0); cyc();
    jump(1'b1, 32'h600, 16'h0); cyc();
    idle(); cyc();
    i_flush = 1'b1; i_flush_tid = 1'b0; cyc();
    idle(); repeat (2) cyc();
    i_ack = 1'b1; repeat (3) cyc();

    // reset in the middle of a handshake
    i_ack = 1'b0;
    jump(1'b0, 32'h700, 16'h0); cyc();
    jump(1'b1, 32'h800, 16'h0); cyc();
    jump(1'b0, 32'h900, 16'h0); cyc();
    idle(); rst = 1'b1; cyc();
    rst = 1'b0; i_ack = 1'b1;
    jump(1'b0, 32'hA00, 16'h0); cyc();
    idle(); repeat (3) cyc();

    // randomized traffic with varying back-pressure
    for (int ph = 0; ph < 4; ph++) begin
      int ack_pct;
      ack_pct = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 10 : 100;
      for (int k = 0; k < 800; k++) begin
        i_ack = ($urandom_range(99) < ack_pct);
        i_stb = 1'b0;
        if ($urandom_range(99) < 60)
          jump(1'($urandom), {$urandom_range(65535), ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00}, 16'($urandom));
        i_flush = ($urandom_range(99) < 5);
        i_flush_tid = 1'($urandom);
        rst = ($urandom_range(999) < 3);
        cyc();
      end
      rst = 1'b0;
    end

    idle(); i_ack = 1'b1; rst = 1'b0;
    repeat (6) cyc();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL xfer_missing: got %0d outstanding expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
